// File: rtl/sobel_line_sched.sv
// Sequencing controller for the Sobel 3x3 line-buffer datapath: tracks pixel
// position, drives the two line FIFOs and emits window shift/valid strobes.
module sobel_line_sched #(
  parameter int H_PIX = 200,
  parameter int V_PIX = 200,
  parameter int CW    = 8,
  parameter int TMO   = 4096,
  parameter int TW    = 13
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          rx_flag,
  input  logic [7:0]    rx_data,
  input  logic          frm_abort,
  input  logic          lba_empty,
  input  logic          lbb_empty,
  output logic          lba_wr_en,
  output logic          lba_rd_en,
  output logic          lbb_wr_en,
  output logic          lbb_rd_en,
  output logic          lb_clr,
  output logic [7:0]    pix_d2,
  output logic          win_shift,
  output logic          win_vld,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          frm_done,
  output logic          err_tmo,
  output logic          err_unf
);

  typedef enum logic [2:0] {IDLE, FILL, RUN, DONE, ABORT} state_t;

  state_t        state;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    pix_d1;
  // T+1 stage of the T+2 strobes
  logic          p1_lbb_wr, p1_shift, p1_vld;

  logic          busy, go_abort, tmo_hit, accept, last_pix;
  logic [CW-1:0] nxt_row, nxt_col;

  assign busy     = (state == FILL) || (state == RUN);
  assign go_abort = frm_abort && (state != IDLE);
  assign tmo_hit  = busy && !rx_flag && (idle_cnt == TW'(TMO-1));
  assign accept   = rx_flag && !go_abort && !tmo_hit && ((state == IDLE) || busy);

  // Position the incoming pixel will take; a pixel seen in IDLE is (0,0).
  always_comb begin
    nxt_row = '0;
    nxt_col = '0;
    if (state != IDLE) begin
      if (col == CW'(H_PIX-1)) begin
        nxt_row = row + CW'(1);
      end else begin
        nxt_row = row;
        nxt_col = col + CW'(1);
      end
    end
  end

  assign last_pix = (nxt_row == CW'(V_PIX-1)) && (nxt_col == CW'(H_PIX-1));

  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= IDLE;
      idle_cnt  <= '0;
      pix_d1    <= '0;
      pix_d2    <= '0;
      p1_lbb_wr <= 1'b0;
      p1_shift  <= 1'b0;
      p1_vld    <= 1'b0;
      lba_wr_en <= 1'b0;
      lba_rd_en <= 1'b0;
      lbb_wr_en <= 1'b0;
      lbb_rd_en <= 1'b0;
      lb_clr    <= 1'b0;
      win_shift <= 1'b0;
      win_vld   <= 1'b0;
      row       <= '0;
      col       <= '0;
      frm_done  <= 1'b0;
      err_tmo   <= 1'b0;
      err_unf   <= 1'b0;
    end else begin
      pix_d1    <= rx_data;
      pix_d2    <= pix_d1;
      lba_wr_en <= 1'b0;
      lba_rd_en <= 1'b0;
      lbb_rd_en <= 1'b0;
      p1_lbb_wr <= 1'b0;
      p1_shift  <= 1'b0;
      p1_vld    <= 1'b0;
      lbb_wr_en <= p1_lbb_wr;
      win_shift <= p1_shift;
      win_vld   <= p1_vld;
      lb_clr    <= 1'b0;
      frm_done  <= 1'b0;
      err_unf   <= err_unf | (lba_rd_en & lba_empty) | (lbb_rd_en & lbb_empty);

      if (go_abort || tmo_hit) begin
        // Squash everything in flight so the clear cycle carries no enables.
        state     <= ABORT;
        lb_clr    <= 1'b1;
        lbb_wr_en <= 1'b0;
        win_shift <= 1'b0;
        win_vld   <= 1'b0;
        row       <= '0;
        col       <= '0;
        idle_cnt  <= '0;
        if (tmo_hit) err_tmo <= 1'b1;
      end else if (accept) begin
        row       <= nxt_row;
        col       <= nxt_col;
        idle_cnt  <= '0;
        lba_wr_en <= (nxt_row <= CW'(V_PIX-2));
        lba_rd_en <= (nxt_row >= CW'(1));
        lbb_rd_en <= (nxt_row >= CW'(2));
        p1_lbb_wr <= (nxt_row >= CW'(1)) && (nxt_row <= CW'(V_PIX-2));
        p1_shift  <= (nxt_row >= CW'(2));
        p1_vld    <= (nxt_row >= CW'(2)) && (nxt_col >= CW'(2));
        frm_done  <= last_pix;
        if (last_pix)                  state <= DONE;
        else if (nxt_row >= CW'(2))    state <= RUN;
        else                           state <= FILL;
      end else begin
        case (state)
          DONE, ABORT: begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
          end
          FILL, RUN: idle_cnt <= idle_cnt + TW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sobel_line_sched.sv
// Directed/randomized bench for sobel_line_sched on a 4x4 frame with a
// cycle-indexed expectation model and counting FIFO models for the empty flags.
module tb_sobel_line_sched;

  localparam int H = 4;
  localparam int V = 4;
  localparam int CWP = 8;
  localparam int TMOP = 16;
  localparam int TWP = 5;
  localparam int N = 1024;

  logic sclk = 1'b0;
  logic rst, rx_flag, frm_abort, lba_empty, lbb_empty;
  logic [7:0] rx_data;
  logic lba_wr_en, lba_rd_en, lbb_wr_en, lbb_rd_en, lb_clr, win_shift, win_vld;
  logic frm_done, err_tmo, err_unf;
  logic [7:0] pix_d2;
  logic [CWP-1:0] row, col;

  sobel_line_sched #(.H_PIX(H), .V_PIX(V), .CW(CWP), .TMO(TMOP), .TW(TWP)) dut (
    .sclk(sclk), .rst(rst), .rx_flag(rx_flag), .rx_data(rx_data),
    .frm_abort(frm_abort), .lba_empty(lba_empty), .lbb_empty(lbb_empty),
    .lba_wr_en(lba_wr_en), .lba_rd_en(lba_rd_en), .lbb_wr_en(lbb_wr_en),
    .lbb_rd_en(lbb_rd_en), .lb_clr(lb_clr), .pix_d2(pix_d2),
    .win_shift(win_shift), .win_vld(win_vld), .row(row), .col(col),
    .frm_done(frm_done), .err_tmo(err_tmo), .err_unf(err_unf)
  );

  always #5 sclk = ~sclk;

  int vecs = 0, errs = 0, cyc = 0;
  int cnt_a = 0, cnt_b = 0;
  bit force_a = 0;
  assign lba_empty = (cnt_a == 0) || force_a;
  assign lbb_empty = (cnt_b == 0);

  // expectations, indexed by the clock edge after which the value is visible
  bit       e_lbawr [0:N-1], e_lbard [0:N-1], e_lbbwr [0:N-1], e_lbbrd [0:N-1];
  bit       e_clr [0:N-1], e_sh [0:N-1], e_vld [0:N-1], e_done [0:N-1];
  bit       e_tmo [0:N-1], e_unf [0:N-1];
  bit [7:0] e_pix [0:N-1], e_row [0:N-1], e_col [0:N-1];

  // model: pixel index within the frame plus busy / one-cycle-hold flags
  int m_idx = 0, m_idle = 0, m_row = 0, m_col = 0;
  bit m_busy = 0, m_hold = 0, m_tmo = 0, m_unf = 0;

  int pc_awr, pc_ard, pc_bwr, pc_brd, pc_vld, pc_done, pc_clr, tmo_edge;

  task automatic model(input int k, input logic f, input logic [7:0] d,
                       input logic ab, input logic rs, input logic ea, input logic eb);
    bit go_ab, tmo, acc;
    int r, c;
    if (rs) begin
      e_lbbwr[k+1] = 0; e_sh[k+1] = 0; e_vld[k+1] = 0;
      e_pix[k] = 0; e_pix[k+1] = 0;
      m_idx = 0; m_idle = 0; m_row = 0; m_col = 0;
      m_busy = 0; m_hold = 0; m_tmo = 0; m_unf = 0;
      e_row[k] = 0; e_col[k] = 0; e_tmo[k] = 0; e_unf[k] = 0;
      e_lbbwr[k] = 0; e_sh[k] = 0; e_vld[k] = 0;
      return;
    end
    if ((e_lbard[k-1] && ea) || (e_lbbrd[k-1] && eb)) m_unf = 1;
    e_pix[k+1] = d;
    go_ab = ab && (m_busy || m_hold);
    tmo   = !go_ab && m_busy && !f && (m_idle == TMOP-1);
    acc   = !go_ab && !tmo && f && !m_hold;
    if (go_ab || tmo) begin
      e_clr[k] = 1; e_lbbwr[k] = 0; e_sh[k] = 0; e_vld[k] = 0;
      m_busy = 0; m_hold = 1; m_idx = 0; m_row = 0; m_col = 0; m_idle = 0;
      if (tmo) m_tmo = 1;
    end else if (acc) begin
      r = m_idx / H; c = m_idx % H;
      m_row = r; m_col = c;
      e_lbawr[k]   = (r <= V-2);
      e_lbard[k]   = (r >= 1);
      e_lbbrd[k]   = (r >= 2);
      e_lbbwr[k+1] = (r >= 1) && (r <= V-2);
      e_sh[k+1]    = (r >= 2);
      e_vld[k+1]   = (r >= 2) && (c >= 2);
      m_idx++; m_idle = 0;
      if (m_idx == H*V) begin
        e_done[k] = 1; m_busy = 0; m_hold = 1; m_idx = 0;
      end else m_busy = 1;
    end else if (m_hold) begin
      m_hold = 0; m_row = 0; m_col = 0;
    end else if (m_busy) m_idle++;
    e_row[k] = 8'(m_row); e_col[k] = 8'(m_col);
    e_tmo[k] = m_tmo; e_unf[k] = m_unf;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s @edge %0d: got %0h want %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_all(input int k);
    chk("lba_wr_en", 8'(lba_wr_en), 8'(e_lbawr[k]));
    chk("lba_rd_en", 8'(lba_rd_en), 8'(e_lbard[k]));
    chk("lbb_wr_en", 8'(lbb_wr_en), 8'(e_lbbwr[k]));
    chk("lbb_rd_en", 8'(lbb_rd_en), 8'(e_lbbrd[k]));
    chk("lb_clr",    8'(lb_clr),    8'(e_clr[k]));
    chk("win_shift", 8'(win_shift), 8'(e_sh[k]));
    chk("win_vld",   8'(win_vld),   8'(e_vld[k]));
    chk("frm_done",  8'(frm_done),  8'(e_done[k]));
    chk("err_tmo",   8'(err_tmo),   8'(e_tmo[k]));
    chk("err_unf",   8'(err_unf),   8'(e_unf[k]));
    chk("pix_d2",    pix_d2,        e_pix[k]);
    chk("row",       row,           e_row[k]);
    chk("col",       col,           e_col[k]);
    pc_awr  += int'(lba_wr_en); pc_ard += int'(lba_rd_en);
    pc_bwr  += int'(lbb_wr_en); pc_brd += int'(lbb_rd_en);
    pc_vld  += int'(win_vld);   pc_done += int'(frm_done);
    pc_clr  += int'(lb_clr);
    if (err_tmo === 1'b1 && tmo_edge == 0) tmo_edge = k;
  endtask

  task automatic clr_pc();
    pc_awr = 0; pc_ard = 0; pc_bwr = 0; pc_brd = 0;
    pc_vld = 0; pc_done = 0; pc_clr = 0;
  endtask

  // one clock: drive at negedge, model the coming edge, then sample after it
  task automatic step(input logic f, input logic ab, input logic rs);
    logic [7:0] d;
    d = 8'($urandom);
    rx_flag = f; rx_data = d; frm_abort = ab; rst = rs;
    model(cyc + 1, f, d, ab, rs, lba_empty, lbb_empty);
    @(posedge sclk);
    @(negedge sclk);
    cyc++;
    if (rs) begin
      cnt_a = 0; cnt_b = 0;
    end else begin
      cnt_a += int'(e_lbawr[cyc-1]) - int'(e_lbard[cyc-1]);
      cnt_b += int'(e_lbbwr[cyc-1]) - int'(e_lbbrd[cyc-1]);
      if (cnt_a < 0) cnt_a = 0;
      if (cnt_b < 0) cnt_b = 0;
      if (e_clr[cyc-1]) begin cnt_a = 0; cnt_b = 0; end
    end
    check_all(cyc);
  endtask

  task automatic chk_frame_counts();
    chk("cnt_lba_wr", 8'(pc_awr), 8'd12);
    chk("cnt_lba_rd", 8'(pc_ard), 8'd12);
    chk("cnt_lbb_wr", 8'(pc_bwr), 8'd8);
    chk("cnt_lbb_rd", 8'(pc_brd), 8'd8);
    chk("cnt_win_vld", 8'(pc_vld), 8'd4);
    chk("cnt_frm_done", 8'(pc_done), 8'd1);
  endtask

  int last_pix;

  initial begin
    rst = 1; rx_flag = 0; rx_data = 0; frm_abort = 0;
    tmo_edge = 0;
    clr_pc();
    @(negedge sclk);
    repeat (3) step(0, 0, 1);

    // frame at full rate
    clr_pc();
    for (int i = 0; i < H*V; i++) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    chk_frame_counts();

    // same frame, one pixel every third cycle
    clr_pc();
    for (int i = 0; i < H*V; i++) begin
      step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    end
    step(0, 0, 0);
    chk_frame_counts();

    // back-to-back frames with a pixel landing in the done cycle (dropped)
    step(0, 0, 0);
    clr_pc();
    for (int i = 0; i < H*V; i++) step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0);
    chk_frame_counts();
    for (int i = 0; i < H*V; i++) step(1, 0, 0);
    repeat (2) step(0, 0, 0);

    // abort while idle is ignored; abort with a pixel at (2,1)
    step(0, 1, 0); step(0, 0, 0);
    clr_pc();
    for (int i = 0; i < 2*H + 1; i++) step(1, 0, 0);
    step(1, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    last_pix = cyc;
    tmo_edge = 0;
    repeat (22) step(0, 0, 0);
    chk("tmo_latency", 8'(tmo_edge - last_pix), 8'd16);
    chk("lb_clr_pulses", 8'(pc_clr), 8'd2);
    chk("no_frm_done", 8'(pc_done), 8'd0);

    // randomly paced frame
    clr_pc();
    for (int i = 0; i < H*V; i++) begin
      step(1, 0, 0);
      repeat ($urandom_range(0, 3)) step(0, 0, 0);
    end
    repeat (3) step(0, 0, 0);
    chk_frame_counts();

    // lba reported empty during row 1, then reset mid-frame
    for (int i = 0; i < 10; i++) begin
      force_a = (i >= H) && (i < 2*H);
      step(1, 0, 0);
    end
    force_a = 0;
    step(0, 0, 0);
    chk("unf_sticky", 8'(err_unf), 8'd1);
    step(1, 0, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
